// File: rtl/spi_ctrl_core.sv
// SPI mode-0 bus master with a byte valid/ready interface and CS_n framing; 16*DIV clk per byte, strobe on the last SCK fall.
// in_ready is high only in IDLE and WAIT (never in a strobe cycle); WAIT holds CS_n low indefinitely.
// SPI_CTRL_LSB_FIRST_EN selects LSB-first shifting; the default build shifts MSB first.
module spi_ctrl_core #(
    parameter int DIV      = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_stb,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_HOLD, S_GAP
    } state_t;

    localparam logic [7:0] DIV_END   = 8'(DIV - 1);
    localparam logic [7:0] SETUP_END = 8'(CS_SETUP);
    localparam logic [7:0] HOLD_END  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_END   = 8'(CS_GAP - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        last_q, last_d;
    logic        sck_q, sck_d;
    logic        cs_n_q, cs_n_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_stb_q, out_stb_d;
    logic        init_q, init_d;
    logic        accept;
    logic        tx_bit;
    logic [7:0]  tx_next;
    logic [7:0]  rx_next;

`ifdef SPI_CTRL_LSB_FIRST_EN
    assign tx_bit  = tx_q[0];
    assign tx_next = {1'b0, tx_q[7:1]};
    assign rx_next = {spi_miso, rx_q[7:1]};
`else
    assign tx_bit  = tx_q[7];
    assign tx_next = {tx_q[6:0], 1'b0};
    assign rx_next = {rx_q[6:0], spi_miso};
`endif

    // init_q keeps in_ready low until the first clock after reset release
    assign in_ready = init_q & ((state_q == S_IDLE) | ((state_q == S_WAIT) & ~out_stb_q));
    assign accept   = in_valid & in_ready;
    assign busy     = (state_q != S_IDLE);
    assign spi_sck  = sck_q;
    assign spi_mosi = tx_bit;
    assign spi_cs_n = cs_n_q;
    assign out_data = out_data_q;
    assign out_stb  = out_stb_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        last_d     = last_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        out_data_d = out_data_q;
        out_stb_d  = 1'b0;
        init_d     = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tx_d    = in_data;
                    last_d  = in_last;
                    cs_n_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = S_SETUP;
                end
            end
            // CS_n falls one cycle ahead of the CS_SETUP count
            S_SETUP: begin
                if (cnt_q == SETUP_END) begin
                    cnt_d   = 8'd0;
                    bit_d   = 3'd0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == DIV_END) begin
                    cnt_d = 8'd0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = rx_next;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            out_data_d = rx_q;
                            out_stb_d  = 1'b1;
                            state_d    = last_q ? S_HOLD : S_WAIT;
                        end else begin
                            bit_d = bit_q + 3'd1;
                            tx_d  = tx_next;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (accept) begin
                    tx_d    = in_data;
                    last_d  = in_last;
                    cnt_d   = 8'd0;
                    bit_d   = 3'd0;
                    state_d = S_SHIFT;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_END) begin
                    cs_n_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 3'd0;
            tx_q       <= 8'd0;
            rx_q       <= 8'd0;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            out_data_q <= 8'd0;
            out_stb_q  <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            last_q     <= last_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            out_data_q <= out_data_d;
            out_stb_q  <= out_stb_d;
            init_q     <= init_d;
        end
    end

endmodule

// File: tb/tb_spi_ctrl_core.sv
// Bench for spi_ctrl_core: random and directed byte transfers checked against a bit-level bus model.
module tb_spi_ctrl_core;

    localparam int DIV_P   = 2;
    localparam int SETUP_P = 2;
    localparam int HOLD_P  = 2;
    localparam int GAP_P   = 2;
`ifdef SPI_CTRL_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       spi_sck, spi_mosi, spi_miso, spi_cs_n;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_stb, busy;

    int n_cmp = 0;
    int n_bad = 0;

    int         miso_mode = 0;   // 0 loopback, 1 tied high, 2 device model
    logic [7:0] dev_byte = 8'h00;

    int   stb_cnt = 0, sck_rises = 0, hi_bad = 0, hi_run = 0, cs_falls = 0;
    int   cs_low_run = 0, last_cs_low = 0, gap_run = 0, last_gap = 0, dev_falls = 0;
    bit   gap_on = 1'b0;
    logic sck_prev = 1'b0, cs_prev = 1'b1;
    logic [7:0] rx_log [0:255];
    logic       mosi_log [0:4095];
    logic [2:0] dev_pos;

    spi_ctrl_core #(.DIV(DIV_P), .CS_SETUP(SETUP_P), .CS_HOLD(HOLD_P), .CS_GAP(GAP_P)) dut (
        .clk(clk), .rst_n(rst_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n), .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_stb(out_stb), .busy(busy)
    );

    always #5 clk = ~clk;

    // device shifts out on SCK falling edges, first bit present as soon as CS_n falls
    assign dev_pos = LSB_FIRST ? dev_falls[2:0] : 3'd7 - dev_falls[2:0];
    always_comb begin
        case (miso_mode)
            0:       spi_miso = spi_mosi;
            1:       spi_miso = 1'b1;
            default: spi_miso = dev_byte[dev_pos];
        endcase
    end

    always @(negedge clk) begin
        if (out_stb) begin
            rx_log[stb_cnt % 256] = out_data;
            stb_cnt++;
        end
        if (spi_sck && !sck_prev) begin
            mosi_log[sck_rises % 4096] = spi_mosi;
            sck_rises++;
            hi_run = 0;
        end
        if (spi_sck) hi_run++;
        if (!spi_sck && sck_prev && hi_run != DIV_P) hi_bad++;
        if (!spi_cs_n) cs_low_run++;
        if (!spi_cs_n && cs_prev) cs_falls++;
        if (spi_cs_n && !cs_prev) begin
            last_cs_low = cs_low_run;
            cs_low_run  = 0;
            gap_on      = 1'b1;
            gap_run     = 0;
        end
        if (gap_on) begin
            if (!in_ready) gap_run++;
            else begin
                last_gap = gap_run;
                gap_on   = 1'b0;
            end
        end
        if (spi_cs_n) dev_falls = 0;
        else if (!spi_sck && sck_prev) dev_falls++;
        sck_prev = spi_sck;
        cs_prev  = spi_cs_n;
    end

    function automatic logic exp_bit(input logic [7:0] d, input int i);
        logic [2:0] k;
        k = LSB_FIRST ? 3'(i) : 3'(7 - i);
        return d[k];
    endfunction

    function automatic logic [7:0] mosi_seq(input int r0);
        logic [7:0] s;
        for (int i = 0; i < 8; i++) s[3'(7 - i)] = mosi_log[(r0 + i) % 4096];
        return s;
    endfunction

    function automatic logic [7:0] exp_seq(input logic [7:0] d);
        logic [7:0] s;
        for (int i = 0; i < 8; i++) s[3'(7 - i)] = exp_bit(d, i);
        return s;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input bit keep);
        bit got = 1'b0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            step();
        end
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL send_handshake: in_ready=%b never rose for byte %h", in_ready, d); end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin n_cmp++; n_bad++; $display("FAIL %s_idle_timeout: busy=%b in_ready=%b required 0/1", tag, busy, in_ready); end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b required 1", spi_cs_n); end
        n_cmp++; if (spi_sck !== 1'b0) begin n_bad++; $display("FAIL rst_sck: got %b required 0", spi_sck); end
        n_cmp++; if (spi_mosi !== 1'b0) begin n_bad++; $display("FAIL rst_mosi: got %b required 0", spi_mosi); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data: got %h required 00", out_data); end
        n_cmp++; if (out_stb !== 1'b0) begin n_bad++; $display("FAIL rst_out_stb: got %b required 0", out_stb); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        repeat (3) step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_release_ready_early: got %b required 0", in_ready); end
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_single();
        int s0 = stb_cnt, r0 = sck_rises, h0 = hi_bad;
        miso_mode = 0;
        send_byte(8'hA5, 1'b1, 1'b0);
        wait_idle("single");
        n_cmp++; if (stb_cnt - s0 !== 1) begin n_bad++; $display("FAIL single_stb_count: got %0d required 1", stb_cnt - s0); end
        n_cmp++; if (rx_log[s0 % 256] !== 8'hA5) begin n_bad++; $display("FAIL single_rx: got %h required a5", rx_log[s0 % 256]); end
        n_cmp++; if (sck_rises - r0 !== 8) begin n_bad++; $display("FAIL single_sck_pulses: got %0d required 8", sck_rises - r0); end
        n_cmp++; if (hi_bad - h0 !== 0) begin n_bad++; $display("FAIL single_sck_high_width: %0d pulses not %0d cycles high", hi_bad - h0, DIV_P); end
        n_cmp++; if (last_cs_low !== 1 + SETUP_P + 16 * DIV_P + HOLD_P) begin n_bad++; $display("FAIL single_cs_low: got %0d required %0d", last_cs_low, 1 + SETUP_P + 16 * DIV_P + HOLD_P); end
        n_cmp++; if (last_gap !== GAP_P) begin n_bad++; $display("FAIL single_gap: got %0d required %0d", last_gap, GAP_P); end
        n_cmp++; if (mosi_seq(r0) !== exp_seq(8'hA5)) begin n_bad++; $display("FAIL single_mosi_bits: got %b required %b", mosi_seq(r0), exp_seq(8'hA5)); end
    endtask

    task automatic test_burst();
        int s0 = stb_cnt, c0 = cs_falls, r0 = sck_rises;
        int bound = 1 + SETUP_P + 32 * DIV_P + HOLD_P + 2;
        miso_mode = 1;
        send_byte(8'h12, 1'b0, 1'b1);
        send_byte(8'h34, 1'b1, 1'b0);
        wait_idle("burst");
        n_cmp++; if (stb_cnt - s0 !== 2) begin n_bad++; $display("FAIL burst_stb_count: got %0d required 2", stb_cnt - s0); end
        n_cmp++; if (rx_log[s0 % 256] !== 8'hFF) begin n_bad++; $display("FAIL burst_rx0: got %h required ff", rx_log[s0 % 256]); end
        n_cmp++; if (rx_log[(s0 + 1) % 256] !== 8'hFF) begin n_bad++; $display("FAIL burst_rx1: got %h required ff", rx_log[(s0 + 1) % 256]); end
        n_cmp++; if (cs_falls - c0 !== 1) begin n_bad++; $display("FAIL burst_cs_frames: got %0d required 1", cs_falls - c0); end
        n_cmp++; if (last_cs_low > bound) begin n_bad++; $display("FAIL burst_no_setup: cs low %0d cycles, required at most %0d", last_cs_low, bound); end
        n_cmp++; if (sck_rises - r0 !== 16) begin n_bad++; $display("FAIL burst_sck_pulses: got %0d required 16", sck_rises - r0); end
    endtask

    task automatic test_stall();
        int s0 = stb_cnt, c0 = cs_falls, bad = 0;
        bit ok = 1'b0;
        miso_mode = 0;
        send_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (stb_cnt > s0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin n_cmp++; n_bad++; $display("FAIL stall_stb_timeout: strobes %0d required 1", stb_cnt - s0); end
        step();
        for (int i = 0; i < 50; i++) begin
            if (spi_cs_n !== 1'b0 || spi_sck !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) bad++;
            step();
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stall_hold: %0d cycles not cs_n=0 sck=0 in_ready=1 busy=1", bad); end
        send_byte(8'hFF, 1'b1, 1'b0);
        wait_idle("stall");
        n_cmp++; if (rx_log[s0 % 256] !== 8'h00) begin n_bad++; $display("FAIL stall_rx0: got %h required 00", rx_log[s0 % 256]); end
        n_cmp++; if (rx_log[(s0 + 1) % 256] !== 8'hFF) begin n_bad++; $display("FAIL stall_rx1: got %h required ff", rx_log[(s0 + 1) % 256]); end
        n_cmp++; if (cs_falls - c0 !== 1) begin n_bad++; $display("FAIL stall_cs_frames: got %0d required 1", cs_falls - c0); end
    endtask

    task automatic test_device();
        logic [7:0] tx, dv;
        int s0, r0;
        miso_mode = 2;
        for (int n = 0; n < 6; n++) begin
            dv = (n == 0) ? 8'h3C : 8'($urandom);
            tx = 8'($urandom);
            dev_byte = dv;
            s0 = stb_cnt;
            r0 = sck_rises;
            send_byte(tx, 1'b1, 1'b0);
            wait_idle("device");
            n_cmp++; if (rx_log[s0 % 256] !== dv) begin n_bad++; $display("FAIL device_rx[%0d]: got %h required %h", n, rx_log[s0 % 256], dv); end
            n_cmp++; if (mosi_seq(r0) !== exp_seq(tx)) begin n_bad++; $display("FAIL device_mosi[%0d]: got %b required %b", n, mosi_seq(r0), exp_seq(tx)); end
        end
    endtask

    task automatic test_random_burst();
        logic [7:0] q [$];
        int nb, s0, r0, c0;
        miso_mode = 0;
        for (int rep = 0; rep < 3; rep++) begin
            q.delete();
            nb = $urandom_range(2, 5);
            s0 = stb_cnt;
            r0 = sck_rises;
            c0 = cs_falls;
            for (int i = 0; i < nb; i++) begin
                q.push_back(8'($urandom));
                send_byte(q[i], (i == nb - 1), (i != nb - 1));
            end
            wait_idle("rburst");
            n_cmp++; if (stb_cnt - s0 !== nb) begin n_bad++; $display("FAIL rburst_stb_count: got %0d required %0d", stb_cnt - s0, nb); end
            n_cmp++; if (cs_falls - c0 !== 1) begin n_bad++; $display("FAIL rburst_cs_frames: got %0d required 1", cs_falls - c0); end
            for (int i = 0; i < nb; i++) begin
                n_cmp++; if (rx_log[(s0 + i) % 256] !== q[i]) begin n_bad++; $display("FAIL rburst_rx[%0d]: got %h required %h", i, rx_log[(s0 + i) % 256], q[i]); end
                n_cmp++; if (mosi_seq(r0 + 8 * i) !== exp_seq(q[i])) begin n_bad++; $display("FAIL rburst_mosi[%0d]: got %b required %b", i, mosi_seq(r0 + 8 * i), exp_seq(q[i])); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int s0 = stb_cnt, r0 = sck_rises, s1;
        bit ok = 1'b0;
        miso_mode = 0;
        send_byte(8'h96, 1'b1, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (sck_rises - r0 >= 4) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin n_cmp++; n_bad++; $display("FAIL rmid_bit4_timeout: sck rises %0d required 4", sck_rises - r0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL rmid_cs_async: got %b required 1", spi_cs_n); end
        n_cmp++; if (spi_sck !== 1'b0) begin n_bad++; $display("FAIL rmid_sck: got %b required 0", spi_sck); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b required 0", busy); end
        s1 = stb_cnt;
        repeat (3) step();
        n_cmp++; if (stb_cnt !== s0) begin n_bad++; $display("FAIL rmid_no_stb: got %0d strobes required 0", stb_cnt - s0 + (s1 - s1)); end
        rst_n = 1'b1;
        step();
        s0 = stb_cnt;
        r0 = sck_rises;
        send_byte(8'h5A, 1'b1, 1'b0);
        wait_idle("rmid");
        n_cmp++; if (rx_log[s0 % 256] !== 8'h5A || stb_cnt - s0 !== 1) begin n_bad++; $display("FAIL rmid_fresh_rx: got %h (%0d strobes) required 5a (1)", rx_log[s0 % 256], stb_cnt - s0); end
        n_cmp++; if (mosi_seq(r0) !== exp_seq(8'h5A)) begin n_bad++; $display("FAIL rmid_fresh_mosi: got %b required %b", mosi_seq(r0), exp_seq(8'h5A)); end
    endtask

    task automatic test_bit_order();
        int s0 = stb_cnt, r0 = sck_rises;
        logic first_exp = LSB_FIRST ? 1'b1 : 1'b0;
        miso_mode = 0;
        send_byte(8'h01, 1'b1, 1'b0);
        wait_idle("order");
        n_cmp++; if (mosi_log[r0 % 4096] !== first_exp) begin n_bad++; $display("FAIL order_first_bit: got %b required %b", mosi_log[r0 % 4096], first_exp); end
        n_cmp++; if (mosi_seq(r0) !== exp_seq(8'h01)) begin n_bad++; $display("FAIL order_mosi: got %b required %b", mosi_seq(r0), exp_seq(8'h01)); end
        n_cmp++; if (rx_log[s0 % 256] !== 8'h01) begin n_bad++; $display("FAIL order_rx: got %h required 01", rx_log[s0 % 256]); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_device();
        test_random_burst();
        test_reset_mid();
        test_bit_order();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ctrl_core.md
Name: spi_ctrl_core

Overview:
SPI controller (bus master) for the FPGA side of the link, driving the same 4-wire bus that our SPI device cores sit on.
- Byte-oriented user interface: the user hands in bytes with a valid/ready handshake, and each byte is flagged "last" or not to delimit CS_n framing.
- Generates SCK from the system clock using a programmable divider.
- Full duplex: every transmitted byte returns one received byte on a strobe.
- SPI mode 0 only (CPOL=0, CPHA=0).

Parameters:
- DIV, 2, SCK half-period in clk cycles; legal range 1..255.
- CS_SETUP, 2, clk cycles from CS_n falling to the first SCK rising edge; legal range 1..255.
- CS_HOLD, 2, clk cycles from the last SCK falling edge to CS_n rising; legal range 1..255.
- CS_GAP, 2, minimum clk cycles CS_n stays high between transactions; legal range 1..255.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- spi_sck, output, 1, SPI clock, registered.
- spi_mosi, output, 1, controller data out, registered.
- spi_miso, input, 1, device data in.
- spi_cs_n, output, 1, chip select, registered, active low.
- in_data, input, 8, byte to transmit.
- in_last, input, 1, this byte closes the transaction.
- in_valid, input, 1, in_data/in_last are valid.
- in_ready, output, 1, controller accepts a byte this cycle.
- out_data, output, 8, last received byte; held until the next strobe.
- out_stb, output, 1, one-cycle pulse when out_data updates.
- busy, output, 1, high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - spi_cs_n=1, spi_sck=0, spi_mosi=0.
  - out_data=0x00, out_stb=0, busy=0, in_ready=0.
  - FSM goes to IDLE and all counters clear.
  - Reset mid-byte aborts immediately; CS_n rises asynchronously and no out_stb is issued. in_ready rises the first cycle after rst_n deasserts.
- FSM states: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP.
- in_ready is high only in IDLE and WAIT. A byte is accepted when in_valid & in_ready; in_data is loaded into the tx shift register and in_last is latched.
- IDLE: on accept, the next cycle has spi_cs_n=0 and spi_mosi=data[7], and the FSM enters SETUP.
- SETUP: spends CS_SETUP cycles with SCK low, then enters SHIFT.
- SHIFT: runs 8 bits, each bit being DIV cycles SCK low followed by DIV cycles SCK high. Byte time is exactly 16*DIV cycles.
  - Entering the high phase: the same clk edge that raises SCK captures spi_miso into the rx shift register LSB (shift left).
  - Entering the low phase of bits 2..8: MOSI updates to the next tx bit on the SCK falling edge.
  - After the 8th high phase, SCK falls; on that same edge out_data receives the full rx byte and out_stb=1 for one cycle.
  - If the latched last flag is 1, go to HOLD; otherwise go to WAIT.
- WAIT: CS_n stays 0, SCK stays 0, MOSI is held.
  - On accept, the next cycle has MOSI=new data[7] and the FSM enters SHIFT directly, with no SETUP.
  - Minimum inter-byte gap is 1 clk beyond DIV low time.
  - Unbounded stall is allowed.
- HOLD: spends CS_HOLD cycles, then spi_cs_n=1 and the FSM enters GAP.
- GAP: spends CS_GAP cycles with in_ready=0, then returns to IDLE.
- busy=0 only in IDLE.
- A byte is never accepted in the same cycle out_stb fires; acceptance is possible from the following cycle.
- in_valid without in_last keeps CS_n asserted indefinitely (no timeout).

Optional Feature:
Macro SPI_CTRL_LSB_FIRST_EN.
- Defined: bits are transmitted and received LSB first. MOSI starts with data[0]; the rx register shifts right, so MISO enters at bit 7.
- Undefined (default): MSB first, as described above.
- Timing is identical in both cases.

Test Plan:
- Single byte: DIV=2, MOSI looped to MISO, send 0xA5 with last=1.
  - out_data=0xA5 with one out_stb.
  - Exactly 8 SCK pulses, each 2 cycles high.
  - CS_n low for 1+2+32+2 cycles, then in_ready low for 2 GAP cycles.
- Burst: send 0x12, 0x34 (last) back-to-back with in_valid held, MISO tied 1.
  - Two strobes, each with out_data=0xFF.
  - CS_n continuous low; no SETUP between bytes.
- Stall: send byte 0x00 with last=0, hold in_valid=0 for 50 cycles, then send 0xFF with last=1.
  - During the stall: CS_n=0, SCK=0, in_ready=1, busy=1.
  - The second byte then completes normally.
- Device model returns 0x3C: received out_data=0x3C, captured on SCK rising edges.
- Reset mid-transfer: pull rst_n low during bit 4.
  - spi_cs_n goes to 1 with no clk edge, SCK=0, no out_stb.
  - A fresh 0x5A transfer after release succeeds.
- With SPI_CTRL_LSB_FIRST_EN defined: send 0x01 -> MOSI is high during the first bit only; loopback returns out_data=0x01.
